irq_sequencer: RTL and testbench

- Interrupt controller for the NeonFox program counter. It collects external interrupt requests and latches them as pending. It masks and prioritises them.
- It issues a single-cycle `interrupt` pulse with a 4-bit `int_addr` vector to the PC block, but only when the fetch pipeline is in a safe state.
- It stays in service until the decoder signals return-from-interrupt.
- It sits between the peripherals/CSR bus and the PC `interrupt`/`int_addr` inputs.

---
 rtl/irq_seq_pkg.sv | 17 +
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_irq_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_seq_pkg.sv
// Shared types and constants for the NeonFox interrupt sequencer.
// Holds the sequencer FSM states, config register selects and nesting depth.
package irq_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SERVICE
    } state_t;

    localparam logic [1:0] CFG_SEL_MASK = 2'd0;
    localparam logic [1:0] CFG_SEL_CLR  = 2'd1;
    localparam logic [1:0] CFG_SEL_GIE  = 2'd2;

    localparam int NEST_DEPTH = 4;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins (index 0 highest).
// Ports: req_i request vector; vld_o any request set; idx_o winning index.
module irq_prio_enc #(
    parameter int N = 16
) (
    input  logic [N-1:0] req_i,
    output logic         vld_o,
    output logic [3:0]   idx_o
);

    always_comb begin
        vld_o = 1'b0;
        idx_o = 4'd0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                vld_o = 1'b1;
                idx_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer for the NeonFox PC: latches, masks and prioritises
// irq edges and issues a one-cycle interrupt/int_addr when fetch is safe.
// Ports: clk/rst (async, active-high); irq request lines; cfg_we/cfg_sel/
// cfg_wdata config bus; hazard/branch_hazard/p_cache_miss/pc_stall safety
// inputs; reti return-from-interrupt; interrupt/int_addr to the PC;
// in_service, pending, int_mask, gie status.
// Optional macro IRQ_SEQ_NEST_EN: preemption with a 4-level stack and a
// cur_level output.
module irq_sequencer
    import irq_seq_pkg::*;
#(
    parameter int NUM_IRQ     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [15:0]        cfg_wdata,
    input  logic               hazard,
    input  logic               branch_hazard,
    input  logic               p_cache_miss,
    input  logic               pc_stall,
    input  logic               reti,
    output logic               interrupt,
    output logic [3:0]         int_addr,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] int_mask,
    output logic               gie
`ifdef IRQ_SEQ_NEST_EN
    ,
    output logic [3:0]         cur_level
`endif
);

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] req;
    logic [NUM_IRQ-1:0] win_oh;
    logic               gie_q, gie_d;
    logic [3:0]         addr_q, addr_d;
    state_t             state_q, state_d;
    logic               win_vld;
    logic [3:0]         win_idx;
    logic               safe;

    assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign req    = pend_q & mask_q;
    assign win_oh = NUM_IRQ'(1) << win_idx;
    assign safe   = ~(hazard | branch_hazard | p_cache_miss | pc_stall);

    irq_prio_enc #(.N(NUM_IRQ)) u_win (
        .req_i (req),
        .vld_o (win_vld),
        .idx_o (win_idx)
    );

`ifdef IRQ_SEQ_NEST_EN
    logic [NEST_DEPTH-1:0][3:0] stk_q, stk_d;
    logic [3:0]         lvl_q, lvl_d;
    logic [2:0]         act_q, act_d;
    logic [NUM_IRQ-1:0] above;
    logic [NUM_IRQ-1:0] pre_oh;
    logic               pre_vld;
    logic [3:0]         pre_idx;

    // Only requests strictly above the active level may preempt.
    assign above  = req & ((NUM_IRQ'(1) << lvl_q) - NUM_IRQ'(1));
    assign pre_oh = NUM_IRQ'(1) << pre_idx;

    irq_prio_enc #(.N(NUM_IRQ)) u_pre (
        .req_i (above),
        .vld_o (pre_vld),
        .idx_o (pre_idx)
    );

    assign cur_level = lvl_q;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        gie_d   = gie_q;
        clr     = '0;
`ifdef IRQ_SEQ_NEST_EN
        stk_d   = stk_q;
        lvl_d   = lvl_q;
        act_d   = act_q;
`endif

        if (cfg_we) begin
            case (cfg_sel)
                CFG_SEL_MASK: mask_d = cfg_wdata[NUM_IRQ-1:0];
                CFG_SEL_CLR:  clr    = cfg_wdata[NUM_IRQ-1:0];
                CFG_SEL_GIE:  gie_d  = cfg_wdata[0];
                default:      ;
            endcase
        end

        unique case (state_q)
            IDLE: begin
                if (gie_q && win_vld && safe) begin
                    state_d = ISSUE;
                    addr_d  = win_idx;
                    clr     = clr | win_oh;
`ifdef IRQ_SEQ_NEST_EN
                    lvl_d   = win_idx;
                    act_d   = 3'd1;
`endif
                end
            end
            ISSUE: state_d = SERVICE;
            SERVICE: begin
`ifdef IRQ_SEQ_NEST_EN
                if (reti) begin
                    if (act_q > 3'd1) begin
                        lvl_d = stk_q[0];
                        stk_d = {4'd0, stk_q[NEST_DEPTH-1:1]};
                        act_d = act_q - 3'd1;
                    end else begin
                        state_d = IDLE;
                        act_d   = 3'd0;
                    end
                end else if (gie_q && safe && pre_vld &&
                             act_q < 3'(NEST_DEPTH)) begin
                    state_d = ISSUE;
                    addr_d  = pre_idx;
                    clr     = clr | pre_oh;
                    stk_d   = {stk_q[NEST_DEPTH-2:0], lvl_q};
                    lvl_d   = pre_idx;
                    act_d   = act_q + 3'd1;
                end
`else
                if (reti) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge always survives a same-cycle clear.
        pend_d = (pend_q & ~clr) | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            gie_q   <= 1'b0;
            addr_q  <= 4'd0;
            state_q <= IDLE;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], irq};
            prev_q  <= sync_q[SYNC_STAGES-1];
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            gie_q   <= gie_d;
            addr_q  <= addr_d;
            state_q <= state_d;
        end
    end

`ifdef IRQ_SEQ_NEST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stk_q <= '0;
            lvl_q <= 4'd0;
            act_q <= 3'd0;
        end else begin
            stk_q <= stk_d;
            lvl_q <= lvl_d;
            act_q <= act_d;
        end
    end
`endif

    assign interrupt  = (state_q == ISSUE);
    assign in_service = (state_q != IDLE);
    assign int_addr   = addr_q;
    assign pending    = pend_q;
    assign int_mask   = mask_q;
    assign gie        = gie_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed scenarios plus random stimulus,
// all checked cycle by cycle against a behavioural model.
module tb_irq_sequencer;

    localparam int N = 16;
    localparam int S = 2;
    localparam int FULL = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] irq = '0;
    logic         cfg_we = 1'b0;
    logic [1:0]   cfg_sel = 2'd0;
    logic [15:0]  cfg_wdata = 16'd0;
    logic         hazard = 1'b0;
    logic         branch_hazard = 1'b0;
    logic         p_cache_miss = 1'b0;
    logic         pc_stall = 1'b0;
    logic         reti = 1'b0;
    logic         interrupt;
    logic [3:0]   int_addr;
    logic         in_service;
    logic [N-1:0] pending;
    logic [N-1:0] int_mask;
    logic         gie;
`ifdef IRQ_SEQ_NEST_EN
    logic [3:0]   cur_level;
`endif

    int total = 0;
    int bad = 0;

    irq_sequencer #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
        .clk           (clk),
        .rst           (rst),
        .irq           (irq),
        .cfg_we        (cfg_we),
        .cfg_sel       (cfg_sel),
        .cfg_wdata     (cfg_wdata),
        .hazard        (hazard),
        .branch_hazard (branch_hazard),
        .p_cache_miss  (p_cache_miss),
        .pc_stall      (pc_stall),
        .reti          (reti),
        .interrupt     (interrupt),
        .int_addr      (int_addr),
        .in_service    (in_service),
        .pending       (pending),
        .int_mask      (int_mask),
        .gie           (gie)
`ifdef IRQ_SEQ_NEST_EN
        ,
        .cur_level     (cur_level)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural reference: pending set, active handler, pulse flag.
    int m_pend, m_mask, m_gie, m_pulse, m_act, m_addr, m_lvl;
    int m_hist[$];
    int m_stk[$];

    function automatic int lowest(input int v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic mdl_reset();
        m_pend = 0; m_mask = 0; m_gie = 0;
        m_pulse = 0; m_act = 0; m_addr = 0; m_lvl = 0;
        m_hist.delete();
        m_stk.delete();
        for (int i = 0; i < S + 2; i++) m_hist.push_back(0);
    endtask

    // One clock edge: an irq rise sampled at edge t becomes pending at t+S.
    task automatic mdl_step();
        int rise, req, w, clr, o_pend, o_gie, o_pulse;
        bit safe, iss;
        if (rst) begin
            mdl_reset();
            return;
        end
        m_hist.push_front(int'(irq));
        rise = m_hist[S] & ~m_hist[S + 1];
        void'(m_hist.pop_back());
        o_pend = m_pend; o_gie = m_gie; o_pulse = m_pulse;
        req = m_pend & m_mask;
        w = lowest(req);
        safe = !(hazard || branch_hazard || p_cache_miss || pc_stall);
        clr = 0;
        iss = 0;
        m_pulse = 0;
        if (cfg_we) begin
            case (cfg_sel)
                2'd0: m_mask = int'(cfg_wdata) & FULL;
                2'd1: clr = int'(cfg_wdata) & FULL;
                2'd2: m_gie = int'(cfg_wdata[0]);
                default: ;
            endcase
        end
        if (m_act == 0) begin
            iss = (o_gie != 0) && (w >= 0) && safe;
        end else if (o_pulse != 0) begin
            // ISSUE cycle: reti ignored, moves to service
        end else if (reti) begin
`ifdef IRQ_SEQ_NEST_EN
            if (m_stk.size() > 0) m_lvl = m_stk.pop_back();
            else m_act = 0;
`else
            m_act = 0;
`endif
        end
`ifdef IRQ_SEQ_NEST_EN
        else if (o_gie != 0 && safe && w >= 0 && w < m_lvl &&
                 m_stk.size() < 3) begin
            m_stk.push_back(m_lvl);
            iss = 1;
        end
`endif
        if (iss) begin
            m_pulse = 1;
            m_act = 1;
            m_addr = w;
            m_lvl = w;
            clr = clr | (1 << w);
        end
        m_pend = ((o_pend & ~clr) | rise) & FULL;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cmp_all();
        check("int", 32'(interrupt), m_pulse);
        check("addr", 32'(int_addr), m_addr);
        check("insvc", 32'(in_service), m_act);
        check("pend", 32'(pending), m_pend);
        check("mask", 32'(int_mask), m_mask);
        check("gie", 32'(gie), m_gie);
`ifdef IRQ_SEQ_NEST_EN
        check("lvl", 32'(cur_level), m_lvl);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_step();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic cfg_write(input logic [1:0] s, input logic [15:0] d);
        cfg_we = 1'b1; cfg_sel = s; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] b);
        irq = irq | b;
        tick();
        irq = irq & ~b;
    endtask

    task automatic do_reti();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    task automatic wait_int(input int max, output int n);
        n = 0;
        while (!interrupt && n < max) begin
            tick();
            n++;
        end
        if (!interrupt) check("wait_tmo", 32'(interrupt), 1);
    endtask

    task automatic quiet(input int cyc, input string tag);
        bit seen = 0;
        for (int i = 0; i < cyc; i++) begin
            tick();
            if (interrupt) seen = 1;
        end
        check(tag, 32'(seen), 0);
    endtask

    initial begin
        int n;
        logic [15:0] t;

        mdl_reset();
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        check("rst_int", 32'(interrupt), 0);
        check("rst_svc", 32'(in_service), 0);
        check("rst_pend", 32'(pending), 0);
        check("rst_mask", 32'(int_mask), 0);

        // Basic issue and latency
        cfg_write(2'd0, 16'h0005);
        cfg_write(2'd2, 16'h0001);
        irq = 16'h0004;
        wait_int(12, n);
        irq = '0;
        check("t1_lat", n, S + 2);
        check("t1_addr", 32'(int_addr), 2);
        check("t1_pend2", 32'(pending[2]), 0);
        tick();
        check("t1_nopulse", 32'(interrupt), 0);
        tick();
        check("t1_svc", 32'(in_service), 1);
        do_reti();
        check("t1_idle", 32'(in_service), 0);

        // Two simultaneous requests: priority, then back-to-back issue
        pulse(16'h0005);
        wait_int(12, n);
        check("t2_first", 32'(int_addr), 0);
        tick();
        tick();
        do_reti();
        wait_int(4, n);
        check("t2_gap", n, 1);
        check("t2_second", 32'(int_addr), 2);
        tick();
        do_reti();

        // Each unsafe condition holds off the issue
        for (int k = 0; k < 4; k++) begin
            hazard = (k == 0);
            p_cache_miss = (k == 1);
            pc_stall = (k == 2);
            branch_hazard = (k == 3);
            pulse(16'h0001);
            quiet(10, "t3_hold");
            hazard = 0; p_cache_miss = 0; pc_stall = 0; branch_hazard = 0;
            wait_int(4, n);
            check("t3_gap", n, 1);
            check("t3_addr", 32'(int_addr), 0);
            tick();
            do_reti();
        end

        // Masked pending, late unmask, clear/set collision, sel 3
        cfg_write(2'd0, 16'h0000);
        pulse(16'h0008);
        quiet(S + 2, "t4_masked");
        check("t4_pend3", 32'(pending[3]), 1);
        cfg_write(2'd0, 16'h0008);
        wait_int(3, n);
        check("t4_addr", 32'(int_addr), 3);
        tick();
        do_reti();
        cfg_write(2'd0, 16'h0000);
        irq = 16'h0008;
        tick();
        irq = '0;
        repeat (S - 1) tick();
        cfg_write(2'd1, 16'h0008);
        check("t4_setwins", 32'(pending[3]), 1);
        cfg_write(2'd1, 16'h0008);
        check("t4_clr", 32'(pending[3]), 0);
        cfg_write(2'd3, 16'hFFFF);
        check("t4_sel3m", 32'(int_mask), 0);
        check("t4_sel3g", 32'(gie), 1);

        // Reset in service with requests pending
        cfg_write(2'd0, 16'h0010);
        pulse(16'h0010);
        wait_int(12, n);
        check("t5_addr", 32'(int_addr), 4);
        tick();
        pulse(16'h0003);
        repeat (S + 1) tick();
        check("t5_pend", 32'(pending), 3);
        rst = 1'b1;
        #1;
        mdl_reset();
        check("t5_int", 32'(interrupt), 0);
        check("t5_raddr", 32'(int_addr), 0);
        check("t5_svc", 32'(in_service), 0);
        check("t5_rpend", 32'(pending), 0);
        check("t5_mask", 32'(int_mask), 0);
        check("t5_gie", 32'(gie), 0);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        quiet(8, "t5_spur");

`ifdef IRQ_SEQ_NEST_EN
        cfg_write(2'd0, 16'h00FF);
        cfg_write(2'd2, 16'h0001);
        pulse(16'h0020);
        wait_int(12, n);
        check("n_a5", 32'(int_addr), 5);
        tick();
        pulse(16'h0002);
        wait_int(12, n);
        check("n_a1", 32'(int_addr), 1);
        check("n_l1", 32'(cur_level), 1);
        tick();
        pulse(16'h0080);
        quiet(S + 2, "n_hold1");
        do_reti();
        check("n_l5", 32'(cur_level), 5);
        check("n_svc", 32'(in_service), 1);
        quiet(4, "n_nopre7");
        do_reti();
        check("n_idle", 32'(in_service), 0);
        wait_int(4, n);
        check("n_a7", 32'(int_addr), 7);
        tick();
        do_reti();
`endif

        // Random traffic against the model
        t = 16'($urandom);
        cfg_write(2'd0, t | 16'h0001);
        cfg_write(2'd2, 16'h0001);
        for (int c = 0; c < 1500; c++) begin
            t = 16'($urandom & $urandom & $urandom);
            irq = irq ^ t[N-1:0];
            hazard = ($urandom % 6 == 0);
            branch_hazard = ($urandom % 8 == 0);
            p_cache_miss = ($urandom % 8 == 0);
            pc_stall = ($urandom % 8 == 0);
            reti = ($urandom % 5 == 0);
            cfg_we = ($urandom % 10 == 0);
            cfg_sel = 2'($urandom % 4);
            cfg_wdata = 16'($urandom);
            if (cfg_sel == 2'd2) cfg_wdata[0] = ($urandom % 4 != 0);
            tick();
        end
        cfg_we = 1'b0;
        reti = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
